adc_sample_capture: RTL and testbench
=====================================

Name: adc_sample_capture

Overview:
Downstream consumer of the ADC clock generator. Samples the parallel ADC data bus on each one-cycle sample strobe aligned to the generated ADC clock. Discards the ADC pipeline latency, box-car averages 2^avg_log2 raw samples per result, and buffers results in a small FIFO. Software drains the FIFO through the AXI-lite register bank.

Parameters:
DATA_W, 14, ADC data width, unsigned offset-binary
FIFO_DEPTH, 16, result FIFO depth in entries, power of 2, at least 2
CNT_W, 16, width of the num_samples result counter
PIPE_LAT, 3, ADC pipeline latency in strobes, discarded after start

Ports:
ACLK  in  1  system clock, all logic on rising edge
ARESET  in  1  synchronous active-high reset
adc_strobe  in  1  one-ACLK pulse marking a valid adc_data word
adc_data  in  DATA_W  ADC output bus, valid when adc_strobe=1
start  in  1  pulse: begin acquisition run
abort  in  1  pulse: terminate run, FIFO contents kept
fifo_clr  in  1  pulse: flush FIFO and clear overflow
avg_log2  in  3  averaging exponent 0..7, latched at start
num_samples  in  CNT_W  results per run, latched at start; 0 means continuous
rd_en  in  1  FIFO pop request
rd_data  out  DATA_W  popped result
rd_valid  out  1  one-cycle pulse, rd_data valid
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
fifo_empty  out  1  fifo_count==0
fifo_full  out  1  fifo_count==FIFO_DEPTH
overflow  out  1  sticky: result dropped because FIFO was full
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at normal run completion
min_val  out  DATA_W  optional feature, see below
max_val  out  DATA_W  optional feature, see below

Behaviour:
- Reset values: all outputs 0 except fifo_empty=1 and min_val = all-ones. State is IDLE, FIFO pointers 0, accumulator 0.
- FSM states: IDLE, FLUSH, ACQ.
  - IDLE: start moves to FLUSH and latches avg_log2, num_samples, and a flush counter of PIPE_LAT. Strobes are ignored in IDLE.
  - FLUSH: each strobe decrements the flush counter. At 0 the FSM moves to ACQ. If PIPE_LAT=0, the FSM goes directly from IDLE to ACQ.
  - ACQ: each strobe adds adc_data to an accumulator of width DATA_W+7 and increments the sample counter.
  - When the sample counter reaches 2^avg_log2, the FIFO write occurs on the next ACLK. The written value is accumulator >> avg_log2, truncated (no rounding), lower DATA_W bits. The accumulator and sample counter clear on that same cycle, so a strobe on that cycle starts the next sum with no lost sample.
  - Result counter increments per result. When it reaches num_samples (num_samples != 0), the FSM returns to IDLE and done pulses together with the final FIFO write.
- abort in any state: return to IDLE next cycle. The partial accumulator is discarded, there is no done pulse, and the FIFO is untouched.
- abort has priority over start. start while busy is ignored.
- FIFO write when full: the result is dropped, overflow is set, and the run continues. The exception: if rd_en is also asserted that cycle and fifo is not empty, the write is accepted and fifo_count is unchanged.
- Read: rd_en with fifo_empty=0 gives rd_data and rd_valid=1 on the next cycle. rd_en on empty is ignored, with no rd_valid and no pointer change. Pointers wrap modulo FIFO_DEPTH.
- rd_data holds its last value between pops.
- fifo_clr: pointers and count go to 0 and overflow clears on the next cycle. A same-cycle push or pop is discarded. fifo_clr does not change FSM state.
- Latency: last strobe of a group at cycle N gives the FIFO write at N+1, fifo_count updated at N+2, and the earliest rd_valid at N+3.

Optional Feature:
ADC_CAPTURE_MINMAX_EN.
- Defined: min_val and max_val track the raw (pre-average) minimum and maximum of every ACQ-state strobe. They reload to all-ones and 0 respectively on start, update the cycle after each strobe, and hold after the run ends.
- Undefined: both ports are driven constant 0 and no tracking logic is generated.

Test Plan:
- Average: avg_log2=2, num_samples=3, PIPE_LAT=3, data 100,101,…,114 on 15 strobes. First 3 strobes are discarded. FIFO gets 104, 108, 112. done pulses once; busy drops on the same cycle.
- Truncation: avg_log2=1, samples 3 and 4 -> result 3. avg_log2=0 passes raw samples unchanged.
- Overflow: continuous run (num_samples=0), avg_log2=0, no reads, 20 strobes. fifo_full=1, fifo_count=16, overflow=1, FIFO holds the first 16 post-flush samples in order. fifo_clr then sets count=0 and overflow=0.
- Full with simultaneous read: FIFO full, rd_en asserted on the write cycle. Write is accepted, count stays 16, no overflow.
- Abort/start: abort mid-group after 2 of 4 samples. No write and busy=0 next cycle. start together with abort is ignored. A new run behaves as in the first scenario.
- Reset mid-run: ARESET during ACQ with 5 FIFO entries. All outputs return to reset values next cycle and rd_en yields no rd_valid.

Source files
------------

// File: rtl/adc_sample_capture_if.sv
// Result-FIFO read port of adc_sample_capture: pop handshake plus occupancy flags.
// master = software/register-bank side, slave = capture block.
interface adc_sample_capture_if #(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  modport master (
    output rd_en,
    input  rd_data, rd_valid, fifo_count, fifo_empty, fifo_full
  );

  modport slave (
    input  rd_en,
    output rd_data, rd_valid, fifo_count, fifo_empty, fifo_full
  );
endinterface

// File: rtl/adc_sample_capture.sv
// ADC sample capture: pipeline-latency flush, 2^avg_log2 box-car averaging, result FIFO.
// Optional raw min/max tracking is enabled by defining ADC_CAPTURE_MINMAX_EN.
module adc_sample_capture #(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PIPE_LAT   = 3
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                adc_strobe,
  input  logic [DATA_W-1:0]   adc_data,
  input  logic                start,
  input  logic                abort,
  input  logic                fifo_clr,
  input  logic [2:0]          avg_log2,
  input  logic [CNT_W-1:0]    num_samples,
  adc_sample_capture_if.slave rd,
  output logic                overflow,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   min_val,
  output logic [DATA_W-1:0]   max_val
);
  localparam int unsigned ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ACC_W   = DATA_W + 7;
  localparam int unsigned SCNT_W  = 8;
  localparam int unsigned FLUSH_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    ACQ   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]         avg_q;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   res_cnt_q;
  logic [FLUSH_W-1:0] flush_q;
  logic [ACC_W-1:0]   acc_q;
  logic [SCNT_W-1:0]  scnt_q;

  logic               start_ok_c;
  logic               wr_req_c;
  logic               last_c;
  logic [DATA_W-1:0]  res_c;

  // Group completes the cycle after its last strobe; abort cancels the pending write.
  assign start_ok_c = (state_q == IDLE) && start && !abort;
  assign wr_req_c   = (state_q == ACQ) && (scnt_q == (SCNT_W'(1) << avg_q)) && !abort;
  assign last_c     = wr_req_c && (num_q != '0) && ((res_cnt_q + CNT_W'(1)) == num_q);
  assign res_c      = DATA_W'(acc_q >> avg_q);

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = (PIPE_LAT == 0) ? ACQ : FLUSH;
        FLUSH:   if (adc_strobe && (flush_q == FLUSH_W'(1))) state_d = ACQ;
        ACQ:     if (last_c) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= last_c;
    end
  end

  // Run parameters, flush counter and averaging accumulator
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      avg_q     <= '0;
      num_q     <= '0;
      res_cnt_q <= '0;
      flush_q   <= '0;
      acc_q     <= '0;
      scnt_q    <= '0;
    end else if (start_ok_c) begin
      avg_q     <= avg_log2;
      num_q     <= num_samples;
      res_cnt_q <= '0;
      flush_q   <= FLUSH_W'(PIPE_LAT);
      acc_q     <= '0;
      scnt_q    <= '0;
    end else if (state_d == IDLE) begin
      acc_q  <= '0;
      scnt_q <= '0;
    end else begin
      if ((state_q == FLUSH) && adc_strobe) flush_q <= flush_q - FLUSH_W'(1);
      if (state_q == ACQ) begin
        if (wr_req_c) begin
          // Clearing and a same-cycle strobe overlap so no sample is lost.
          res_cnt_q <= res_cnt_q + CNT_W'(1);
          acc_q     <= adc_strobe ? ACC_W'(adc_data) : '0;
          scnt_q    <= adc_strobe ? SCNT_W'(1) : '0;
        end else if (adc_strobe) begin
          acc_q  <= acc_q + ACC_W'(adc_data);
          scnt_q <= scnt_q + SCNT_W'(1);
        end
      end
    end
  end

  // Result FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              empty_q, full_q;
  logic              pop_c, push_c, drop_c, is_full_c;

  // A pop on a full FIFO frees the slot for a same-cycle push.
  assign is_full_c = (count_q == FCNT_W'(FIFO_DEPTH));
  assign pop_c     = rd.rd_en && (count_q != '0) && !fifo_clr;
  assign push_c    = wr_req_c && !fifo_clr && (!is_full_c || pop_c);
  assign drop_c    = wr_req_c && !fifo_clr && is_full_c && !pop_c;

  always_comb begin
    count_d = count_q;
    if (fifo_clr)              count_d = '0;
    else if (push_c && !pop_c) count_d = count_q + FCNT_W'(1);
    else if (pop_c && !push_c) count_d = count_q - FCNT_W'(1);
  end

  always_ff @(posedge ACLK) begin
    if (push_c) mem[wr_ptr_q] <= res_c;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_c;
      if (pop_c) rd_data_q <= mem[rd_ptr_q];
      if (fifo_clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_c) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        if (drop_c) overflow <= 1'b1;
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FCNT_W'(FIFO_DEPTH));
    end
  end

  assign rd.rd_data    = rd_data_q;
  assign rd.rd_valid   = rd_valid_q;
  assign rd.fifo_count = count_q;
  assign rd.fifo_empty = empty_q;
  assign rd.fifo_full  = full_q;

`ifdef ADC_CAPTURE_MINMAX_EN
  logic [DATA_W-1:0] min_q, max_q;

  // Raw extremes of every strobe seen while acquiring
  always_ff @(posedge ACLK) begin
    if (ARESET || start_ok_c) begin
      min_q <= '1;
      max_q <= '0;
    end else if ((state_q == ACQ) && adc_strobe) begin
      if (adc_data < min_q) min_q <= adc_data;
      if (adc_data > max_q) max_q <= adc_data;
    end
  end

  assign min_val = min_q;
  assign max_val = max_q;
`else
  assign min_val = '0;
  assign max_val = '0;
`endif

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed self-checking bench for adc_sample_capture (default parameters, PIPE_LAT=3).
module tb_adc_sample_capture;
  localparam int unsigned DATA_W = 14;
  localparam int unsigned DEPTH  = 16;
`ifdef ADC_CAPTURE_MINMAX_EN
  localparam int unsigned MIN_RST = 16383;
  localparam int unsigned EXP_MIN = 103;
  localparam int unsigned EXP_MAX = 114;
`else
  localparam int unsigned MIN_RST = 0;
  localparam int unsigned EXP_MIN = 0;
  localparam int unsigned EXP_MAX = 0;
`endif

  logic              clk;
  logic              rst;
  logic              adc_strobe;
  logic [DATA_W-1:0] adc_data;
  logic              start;
  logic              abort;
  logic              fifo_clr;
  logic [2:0]        avg_log2;
  logic [15:0]       num_samples;
  logic              overflow;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] min_val;
  logic [DATA_W-1:0] max_val;

  int n_checks;
  int n_fail;
  int done_cnt;
  logic done_busy;

  adc_sample_capture_if #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) rd_if ();

  adc_sample_capture dut (
    .ACLK        (clk),
    .ARESET      (rst),
    .adc_strobe  (adc_strobe),
    .adc_data    (adc_data),
    .start       (start),
    .abort       (abort),
    .fifo_clr    (fifo_clr),
    .avg_log2    (avg_log2),
    .num_samples (num_samples),
    .rd          (rd_if),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done),
    .min_val     (min_val),
    .max_val     (max_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and look at outputs 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      done_busy = busy;
    end
  endtask

  task automatic strobe(input int unsigned d);
    adc_strobe = 1'b1;
    adc_data   = DATA_W'(d);
    tick();
    adc_strobe = 1'b0;
    tick();
  endtask

  task automatic run_start(input int unsigned a, input int unsigned n);
    avg_log2    = 3'(a);
    num_samples = 16'(n);
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic pop(input string tag, input int unsigned exp);
    rd_if.rd_en = 1'b1;
    tick();
    rd_if.rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_if.rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_if.rd_data), exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_if.rd_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_if.rd_data), 32'd0);
    chk({tag, "_count"}, 32'(rd_if.fifo_count), 32'd0);
    chk({tag, "_empty"}, 32'(rd_if.fifo_empty), 32'd1);
    chk({tag, "_full"}, 32'(rd_if.fifo_full), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_min"}, 32'(min_val), MIN_RST);
    chk({tag, "_max"}, 32'(max_val), 32'd0);
  endtask

  initial begin
    int d0;
    n_checks    = 0;
    n_fail      = 0;
    done_cnt    = 0;
    done_busy   = 1'b1;
    rst         = 1'b1;
    adc_strobe  = 1'b0;
    adc_data    = '0;
    start       = 1'b0;
    abort       = 1'b0;
    fifo_clr    = 1'b0;
    avg_log2    = '0;
    num_samples = '0;
    rd_if.rd_en = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Averaging run: 3 flushed, groups of 4 -> 104, 108, 112
    run_start(2, 3);
    chk("avg_busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < 15; i++) strobe(100 + i);
    tick();
    tick();
    chk("avg_done_once", 32'(done_cnt), 32'd1);
    chk("avg_done_busy", 32'(done_busy), 32'd0);
    chk("avg_count", 32'(rd_if.fifo_count), 32'd3);
    chk("avg_min", 32'(min_val), EXP_MIN);
    chk("avg_max", 32'(max_val), EXP_MAX);
    pop("avg_r0", 104);
    pop("avg_r1", 108);
    pop("avg_r2", 112);
    chk("avg_empty", 32'(rd_if.fifo_empty), 32'd1);
    tick();
    chk("hold_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("hold_data", 32'(rd_if.rd_data), 32'd112);
    rd_if.rd_en = 1'b1;
    tick();
    rd_if.rd_en = 1'b0;
    chk("rd_empty_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("rd_empty_count", 32'(rd_if.fifo_count), 32'd0);

    // Truncation (3+4)/2 -> 3, with write/count/read latency
    d0 = done_cnt;
    run_start(1, 1);
    for (int i = 0; i < 3; i++) strobe(0);
    strobe(3);
    adc_strobe = 1'b1;
    adc_data   = DATA_W'(4);
    tick();
    adc_strobe = 1'b0;
    chk("lat_count_n", 32'(rd_if.fifo_count), 32'd0);
    tick();
    chk("lat_count_n2", 32'(rd_if.fifo_count), 32'd1);
    chk("trunc_done", 32'(done_cnt - d0), 32'd1);
    pop("trunc", 3);
    // avg_log2=0 passes raw samples
    run_start(0, 2);
    for (int i = 0; i < 3; i++) strobe(9);
    strobe(7);
    strobe(5);
    tick();
    chk("raw_done", 32'(done_cnt - d0), 32'd2);
    pop("raw0", 7);
    pop("raw1", 5);

    // Overflow in continuous mode, then flush with fifo_clr
    d0 = done_cnt;
    run_start(0, 0);
    for (int i = 0; i < 20; i++) strobe(200 + i);
    chk("ovf_full", 32'(rd_if.fifo_full), 32'd1);
    chk("ovf_count", 32'(rd_if.fifo_count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd1);
    pop("ovf_r0", 203);
    pop("ovf_r1", 204);
    chk("ovf_count14", 32'(rd_if.fifo_count), 32'd14);
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
    chk("clr_count", 32'(rd_if.fifo_count), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_empty", 32'(rd_if.fifo_empty), 32'd1);
    chk("clr_busy", 32'(busy), 32'd1);

    // Refill to full, then write on a cycle with a pop
    for (int i = 0; i < 16; i++) strobe(300 + i);
    chk("refill_full", 32'(rd_if.fifo_full), 32'd1);
    chk("refill_ovf", 32'(overflow), 32'd0);
    adc_strobe = 1'b1;
    adc_data   = DATA_W'(316);
    tick();
    adc_strobe  = 1'b0;
    rd_if.rd_en = 1'b1;
    tick();
    rd_if.rd_en = 1'b0;
    chk("fullrd_valid", 32'(rd_if.rd_valid), 32'd1);
    chk("fullrd_data", 32'(rd_if.rd_data), 32'd300);
    chk("fullrd_count", 32'(rd_if.fifo_count), 32'd16);
    chk("fullrd_ovf", 32'(overflow), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("cont_abort_busy", 32'(busy), 32'd0);
    chk("cont_no_done", 32'(done_cnt - d0), 32'd0);
    for (int i = 0; i < 16; i++) pop("order", 301 + i);
    chk("order_empty", 32'(rd_if.fifo_empty), 32'd1);

    // Abort mid-group, start+abort ignored, then a clean run
    d0 = done_cnt;
    run_start(2, 3);
    for (int i = 0; i < 3; i++) strobe(0);
    strobe(50);
    strobe(51);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    tick();
    tick();
    chk("abort_count", 32'(rd_if.fifo_count), 32'd0);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    run_start(2, 3);
    avg_log2    = 3'd0;
    num_samples = 16'd1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) strobe(100 + i);
    tick();
    chk("rerun_done", 32'(done_cnt - d0), 32'd1);
    chk("rerun_busy", 32'(busy), 32'd0);
    chk("rerun_count", 32'(rd_if.fifo_count), 32'd3);
    pop("rerun0", 104);
    pop("rerun1", 108);
    pop("rerun2", 112);

    // Synchronous reset during acquisition with 5 entries held
    run_start(0, 0);
    for (int i = 0; i < 8; i++) strobe(400 + i);
    chk("pre_rst_count", 32'(rd_if.fifo_count), 32'd5);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst         = 1'b1;
    rd_if.rd_en = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    tick();
    rd_if.rd_en = 1'b0;
    chk("post_rst_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("post_rst_count", 32'(rd_if.fifo_count), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
